// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the datapath it feeds.
// Contents:
//   seq_state_t      sequencer FSM states
//   OP_*             datapath op_code values (none/store/add/sub)
//   OPC_*/F3_*/F7_*  RISC-V opcode and funct fields recognised by the decoder
//   ERR_*            err_code values
package instruction_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE,
        S_HALT,
        S_ERROR
    } seq_state_t;

    localparam logic [6:0] OP_NONE  = 7'd0;
    localparam logic [6:0] OP_STORE = 7'd1;
    localparam logic [6:0] OP_ADD   = 7'd2;
    localparam logic [6:0] OP_SUB   = 7'd3;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SD     = 3'b011;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Bus between the instruction sequencer, its instruction memory and the datapath.
// i_ signals are inputs to the sequencer, o_ signals are outputs of it.
//   slave  : sequencer side
//   master : environment side (memory, datapath, controller)
// Signals: i_start, o_imem_addr, i_imem_rdata, o_issue_valid, o_rs1, o_rs2, o_rd,
//          o_op_code, o_imm, i_dp_done, o_busy, o_halted, o_error, o_err_code, o_pc
interface instruction_sequencer_if #(
    parameter int WORDSIZE = 64,
    parameter int INSTR_W  = 32,
    parameter int PC_W     = 8
);
    logic                i_start;
    logic [PC_W-1:0]     o_imem_addr;
    logic [INSTR_W-1:0]  i_imem_rdata;
    logic                o_issue_valid;
    logic [4:0]          o_rs1;
    logic [4:0]          o_rs2;
    logic [4:0]          o_rd;
    logic [6:0]          o_op_code;
    logic [WORDSIZE-1:0] o_imm;
    logic                i_dp_done;
    logic                o_busy;
    logic                o_halted;
    logic                o_error;
    logic [1:0]          o_err_code;
    logic [PC_W-1:0]     o_pc;

    modport slave (
        input  i_start, i_imem_rdata, i_dp_done,
        output o_imem_addr, o_issue_valid, o_rs1, o_rs2, o_rd, o_op_code, o_imm,
               o_busy, o_halted, o_error, o_err_code, o_pc
    );

    modport master (
        output i_start, i_imem_rdata, i_dp_done,
        input  o_imem_addr, o_issue_valid, o_rs1, o_rs2, o_rd, o_op_code, o_imm,
               o_busy, o_halted, o_error, o_err_code, o_pc
    );
endinterface

// File: rtl/instruction_sequencer_instr_decoder.sv
// Combinational decoder: instruction word -> datapath fields.
// Ports:
//   i_instr      instruction word
//   o_rs1/o_rs2  source registers (always extracted)
//   o_rd         destination register (0 for store and non-ALU words)
//   o_op_code    OP_NONE/OP_STORE/OP_ADD/OP_SUB
//   o_imm        sign-extended S-immediate for store, otherwise 0
//   o_is_halt    word is all zeros
//   o_is_illegal word is neither halt nor a supported instruction
module instr_decoder
    import instruction_sequencer_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int INSTR_W  = 32
) (
    input  logic [INSTR_W-1:0]  i_instr,
    output logic [4:0]          o_rs1,
    output logic [4:0]          o_rs2,
    output logic [4:0]          o_rd,
    output logic [6:0]          o_op_code,
    output logic [WORDSIZE-1:0] o_imm,
    output logic                o_is_halt,
    output logic                o_is_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    always_comb begin
        o_rs1        = i_instr[19:15];
        o_rs2        = i_instr[24:20];
        o_rd         = 5'd0;
        o_op_code    = OP_NONE;
        o_imm        = '0;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;
        if (i_instr == '0) begin
            o_is_halt = 1'b1;
        end else if (w_opcode == OPC_RTYPE && w_funct3 == F3_ADDSUB && w_funct7 == F7_ADD) begin
            o_op_code = OP_ADD;
            o_rd      = i_instr[11:7];
        end else if (w_opcode == OPC_RTYPE && w_funct3 == F3_ADDSUB && w_funct7 == F7_SUB) begin
            o_op_code = OP_SUB;
            o_rd      = i_instr[11:7];
        end else if (w_opcode == OPC_STORE && w_funct3 == F3_SD) begin
            o_op_code = OP_STORE;
            o_imm     = {{(WORDSIZE-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        end else begin
            o_is_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Upstream control stage for the processor datapath: fetches a word from a
// synchronous instruction memory, decodes it, issues it and waits for the
// datapath to finish before moving on. Stops on a halt word, an illegal word
// or a datapath that never answers.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sequencer side of instruction_sequencer_if (start, memory, issue, status)
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int INSTR_W  = 32,
    parameter int PC_W     = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instruction_sequencer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [TW-1:0]       r_timer;
    logic [4:0]          r_rs1, r_rs2, r_rd;
    logic [6:0]          r_op_code;
    logic [WORDSIZE-1:0] r_imm;
    logic [1:0]          r_err_code;

    logic [4:0]          w_rs1, w_rs2, w_rd;
    logic [6:0]          w_op_code;
    logic [WORDSIZE-1:0] w_imm;
    logic                w_is_halt, w_is_illegal;
    logic                w_timeout;
    logic                w_issue_valid, w_busy, w_halted, w_error;

    instr_decoder #(.WORDSIZE(WORDSIZE), .INSTR_W(INSTR_W)) u_decoder (
        .i_instr      (bus.i_imem_rdata),
        .o_rs1        (w_rs1),
        .o_rs2        (w_rs2),
        .o_rd         (w_rd),
        .o_op_code    (w_op_code),
        .o_imm        (w_imm),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    // r_timer holds the number of WAIT_DONE cycles already completed, so this is
    // the last permitted cycle; dp_done arriving on it still takes priority.
    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_HALT, S_ERROR: if (bus.i_start) w_next_state = S_FETCH;
            S_FETCH:     w_next_state = S_WAIT_MEM;
            S_WAIT_MEM:  w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_is_halt)         w_next_state = S_HALT;
                else if (w_is_illegal) w_next_state = S_ERROR;
                else                   w_next_state = S_ISSUE;
            end
            S_ISSUE:     w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.i_dp_done)  w_next_state = S_FETCH;
                else if (w_timeout) w_next_state = S_ERROR;
            end
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Datapath registers. Decoded fields are captured once in DECODE and then
    // held, which keeps them stable for the whole time issue_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_timer    <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_op_code  <= OP_NONE;
            r_imm      <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            case (r_state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (bus.i_start) begin
                        r_pc       <= '0;
                        r_err_code <= ERR_NONE;
                    end
                end
                S_DECODE: begin
                    r_rs1     <= w_rs1;
                    r_rs2     <= w_rs2;
                    r_rd      <= w_rd;
                    r_op_code <= w_op_code;
                    r_imm     <= w_imm;
                    if (!w_is_halt && w_is_illegal) r_err_code <= ERR_ILLEGAL;
                end
                S_ISSUE: r_timer <= '0;
                S_WAIT_DONE: begin
                    r_timer <= r_timer + TW'(1);
                    if (bus.i_dp_done)  r_pc       <= r_pc + PC_W'(1);
                    else if (w_timeout) r_err_code <= ERR_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    // Status outputs decode straight from the state register; op_code is
    // forced to none whenever no instruction is being issued.
    always_comb begin
        w_issue_valid = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE);
        w_busy        = !(r_state inside {S_IDLE, S_HALT, S_ERROR});
        w_halted      = (r_state == S_HALT);
        w_error       = (r_state == S_ERROR);
    end

    assign bus.o_imem_addr   = r_pc;
    assign bus.o_pc          = r_pc;
    assign bus.o_issue_valid = w_issue_valid;
    assign bus.o_busy        = w_busy;
    assign bus.o_halted      = w_halted;
    assign bus.o_error       = w_error;
    assign bus.o_err_code    = r_err_code;
    assign bus.o_rs1         = r_rs1;
    assign bus.o_rs2         = r_rs2;
    assign bus.o_rd          = r_rd;
    assign bus.o_imm         = r_imm;
    assign bus.o_op_code     = w_issue_valid ? r_op_code : OP_NONE;

endmodule
